// File: rtl/regfile_pkg.sv
// Shared widths, address constants and word/address types for the register file.
// Optional write-through forwarding is selected by REGFILE_WRITE_BYPASS_EN in register_file.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Address 15 is the program counter view, never backed by storage
  localparam addr_t PC_ADDR = 4'hF;

endpackage

// File: rtl/register_file_if.sv
// Register-file access bundle: two read ports, one write port and the PC+8 value.
// The master modport is the datapath side and the slave modport is the register file.
interface register_file_if #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
);

  logic              wr;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [DATA_W-1:0] r15;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  modport master (
    output wr, ra1, ra2, wa, wd, r15,
    input  rd1, rd2
  );

  modport slave (
    input  wr, ra1, ra2, wa, wd, r15,
    output rd1, rd2
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: PC select, optional forwarded write data, else stored word.
// The forwarding inputs are only ever asserted when REGFILE_WRITE_BYPASS_EN is defined.
module regfile_read_port #(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W,
  parameter int NREGS  = (2 ** ADDR_W) - 1
) (
  input  logic [ADDR_W-1:0]            ra,
  input  logic [NREGS-1:0][DATA_W-1:0] regs,
  input  logic [DATA_W-1:0]            r15,
  input  logic                         fwd_valid,
  input  logic [ADDR_W-1:0]            fwd_addr,
  input  logic [DATA_W-1:0]            fwd_data,
  output logic [DATA_W-1:0]            rd
);

  localparam logic [ADDR_W-1:0] PC = {ADDR_W{1'b1}};

  // PC select outranks forwarding so address 15 always shows the live r15 input
  always_comb begin
    rd = regs[ra];
    if (ra == PC) begin
      rd = r15;
    end else if (fwd_valid && (ra == fwd_addr)) begin
      rd = fwd_data;
    end
  end

endmodule

// File: rtl/register_file.sv
// ARM-style register file: r0..r14 stored, r15 reads the external PC+8, two async reads.
// Define REGFILE_WRITE_BYPASS_EN to forward same-cycle write data to matching read ports.
module register_file
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic           clk,
  input  logic           rst_n,
  register_file_if.slave bus
);

  localparam int                NREGS = (2 ** ADDR_W) - 1;
  localparam logic [ADDR_W-1:0] PC    = {ADDR_W{1'b1}};

  logic [NREGS-1:0][DATA_W-1:0] regs_flat;
  logic                         fwd_valid;

  // Writes to address 15 never match any stored index, so they fall away naturally
  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      logic [DATA_W-1:0] q_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          q_reg <= '0;
        end else if (bus.wr && (bus.wa == ADDR_W'(gi))) begin
          q_reg <= bus.wd;
        end
      end

      assign regs_flat[gi] = q_reg;
    end
  endgenerate

`ifdef REGFILE_WRITE_BYPASS_EN
  assign fwd_valid = bus.wr && rst_n && (bus.wa != PC);
`else
  assign fwd_valid = 1'b0;
`endif

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_port1 (
    .ra        (bus.ra1),
    .regs      (regs_flat),
    .r15       (bus.r15),
    .fwd_valid (fwd_valid),
    .fwd_addr  (bus.wa),
    .fwd_data  (bus.wd),
    .rd        (bus.rd1)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_port2 (
    .ra        (bus.ra2),
    .regs      (regs_flat),
    .r15       (bus.r15),
    .fwd_valid (fwd_valid),
    .fwd_addr  (bus.wa),
    .fwd_data  (bus.wd),
    .rd        (bus.rd2)
  );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: shadow register model feeding a scoreboard queue.
// Honours REGFILE_WRITE_BYPASS_EN for the same-cycle read-during-write expectation.
module tb_register_file;
  import regfile_pkg::*;

  typedef struct {
    string tag;
    data_t exp;
  } sb_entry_t;

  logic clk;
  logic rst_n;

  register_file_if bus ();

  register_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int        checks;
  int        errors;
  data_t     model [0:14];
  sb_entry_t sb [$];

  task automatic check(input string tag, input data_t obs, input data_t exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic data_t model_rd(input int a);
    return (a == 15) ? bus.r15 : model[a];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 15; i++) model[i] = '0;
  endtask

  task automatic do_write(input int a, input data_t d);
    bus.wr = 1'b1;
    bus.wa = addr_t'(a);
    bus.wd = d;
    tick();
    bus.wr = 1'b0;
    if (a != 15) model[a] = d;
    $display("write wa=%0d wd=%h", a, d);
  endtask

  // Push expected words when the addresses are driven, pop them once the outputs settle
  task automatic do_read(input string tag, input int a1, input int a2);
    sb_entry_t e;
    bus.ra1 = addr_t'(a1);
    bus.ra2 = addr_t'(a2);
    e.tag = {tag, "_rd1"};
    e.exp = model_rd(a1);
    sb.push_back(e);
    e.tag = {tag, "_rd2"};
    e.exp = model_rd(a2);
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    check(e.tag, bus.rd1, e.exp);
    e = sb.pop_front();
    check(e.tag, bus.rd2, e.exp);
    $display("read ra1=%0d rd1=%h ra2=%0d rd2=%h", a1, bus.rd1, a2, bus.rd2);
  endtask

  initial begin
    data_t hz_exp;
    checks = 0;
    errors = 0;
    rst_n   = 1'b0;
    bus.wr  = 1'b0;
    bus.ra1 = '0;
    bus.ra2 = '0;
    bus.wa  = '0;
    bus.wd  = '0;
    bus.r15 = '0;
    model_clear();

    // Reset
    tick();
    rst_n = 1'b1;
    do_read("reset", 1, 14);
    bus.r15 = 32'h4C;
    do_read("reset_pc", 15, 0);

    // Basic write / read and the top stored register
    do_write(1, 32'hC);
    do_read("wr_r1", 1, 0);
    do_write(4, 32'h8);
    do_read("wr_r4", 1, 4);
    do_write(14, 32'hC25);
    do_read("wr_r14", 4, 14);

    // r15 path, including a discarded write to address 15
    do_read("pc_both", 15, 15);
    bus.r15 = 32'h50;
    do_read("pc_follow", 15, 15);
    do_write(15, 32'hDEAD);
    do_read("pc_nowrite", 15, 15);
    for (int i = 0; i < 15; i++) do_read($sformatf("intact%0d", i), i, 14 - i);

    // Write disable
    bus.wr = 1'b0;
    bus.wa = 4'd1;
    bus.wd = 32'hFF;
    tick();
    do_read("wr_off", 1, 4);

    // Reset wins over a simultaneous write
    rst_n  = 1'b0;
    bus.wr = 1'b1;
    bus.wa = 4'd2;
    bus.wd = 32'h77;
    tick();
    rst_n  = 1'b1;
    bus.wr = 1'b0;
    model_clear();
    do_read("rst_prio", 2, 1);

    // Same-cycle read-during-write
    do_write(3, 32'h11);
    bus.wr  = 1'b1;
    bus.wa  = 4'd3;
    bus.wd  = 32'h22;
    bus.ra1 = 4'd3;
    bus.ra2 = 4'd15;
`ifdef REGFILE_WRITE_BYPASS_EN
    hz_exp = 32'h22;
`else
    hz_exp = 32'h11;
`endif
    #1;
    check("hazard_pre", bus.rd1, hz_exp);
    check("hazard_pc", bus.rd2, 32'h50);
    $display("hazard ra1=3 rd1=%h rd2=%h", bus.rd1, bus.rd2);
    tick();
    bus.wr = 1'b0;
    model[3] = 32'h22;
    do_read("hazard_post", 3, 3);

    // Random writes followed by random reads against the model
    for (int n = 0; n < 40; n++) begin
      do_write($urandom_range(0, 15), $urandom);
      do_read($sformatf("rand%0d", n), $urandom_range(0, 15), $urandom_range(0, 15));
    end
    for (int i = 0; i < 15; i++) do_read($sformatf("final%0d", i), i, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
